systolic_ws_feeder: RTL and testbench

Input-skew feeder placed directly upstream of the weight-stationary systolic PE array. Accepts one activation vector per cycle over a valid/ready handshake and staggers it so that row i reaches the array i cycles after row 0, inserting zeros in idle slots. Tracks when the last vector's final column result has left the array, then pulses `done`. Optionally injects skewed per-column bias on the array's north inputs.

---
 rtl/systolic_ws_feeder.sv | 157 +++++++++++++++
 tb/tb_systolic_ws_feeder.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ws_feeder.sv
// systolic_ws_feeder: skews one activation vector per cycle onto the west
// edge of a weight-stationary systolic array (row i delayed by i+1 cycles),
// fills idle slots with zeros and pulses done when the last vector's final
// column result leaves the array.
// Optional feature macro: SYSTOLIC_WS_FEEDER_BIAS_EN (skewed per-column bias
// on norths; when undefined norths is tied to zero).
module systolic_ws_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROW_NUM    = 8,
  parameter int unsigned COL_NUM    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [DATA_WIDTH-1:0]   in_data    [0:ROW_NUM-1],
  input  logic [DATA_WIDTH*4-1:0] bias       [0:COL_NUM-1],
  output logic [DATA_WIDTH-1:0]   wests      [0:ROW_NUM-1],
  output logic [ROW_NUM-1:0]      lane_valid,
  output logic [DATA_WIDTH*4-1:0] norths     [0:COL_NUM-1],
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned SPAN  = ROW_NUM + COL_NUM;
  localparam int unsigned CNT_W = $clog2(SPAN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q;
  logic             accept;

  assign accept = in_valid && in_ready_q;

  // Next-state decode: DRAIN counts down the array flush before done
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, STREAM: begin
        if (accept) begin
          if (in_last) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(SPAN - 1);
          end else begin
            state_d = STREAM;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and registered ready (held low for one cycle after reset)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= (state_d != DRAIN);
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DRAIN) && (cnt_q == '0);

  // West delay lines: row i is an (i+1)-deep shift register, newest at LSB
  for (genvar i = 0; i < ROW_NUM; i++) begin : g_row
    localparam int unsigned DEPTH = i + 1;
    logic [DEPTH*DATA_WIDTH-1:0] d_q;
    logic [DEPTH-1:0]            v_q;
    logic [DATA_WIDTH-1:0]       head;

    assign head = accept ? in_data[i] : '0;

    if (i == 0) begin : g_one
      // Single-stage line for row 0
      always_ff @(posedge clk) begin
        if (reset) begin
          d_q <= '0;
          v_q <= '0;
        end else begin
          d_q <= head;
          v_q <= accept;
        end
      end
    end else begin : g_many
      // Multi-stage line, shifts every cycle
      always_ff @(posedge clk) begin
        if (reset) begin
          d_q <= '0;
          v_q <= '0;
        end else begin
          d_q <= {d_q[(DEPTH-1)*DATA_WIDTH-1:0], head};
          v_q <= {v_q[DEPTH-2:0], accept};
        end
      end
    end

    assign wests[i]      = d_q[DEPTH*DATA_WIDTH-1 -: DATA_WIDTH];
    assign lane_valid[i] = v_q[DEPTH-1];
  end

`ifdef SYSTOLIC_WS_FEEDER_BIAS_EN
  // North bias lines: column j is a (j+1)-deep shift register
  for (genvar j = 0; j < COL_NUM; j++) begin : g_col
    localparam int unsigned DEPTH = j + 1;
    localparam int unsigned BW    = DATA_WIDTH * 4;
    logic [DEPTH*BW-1:0] b_q;
    logic [BW-1:0]       head;

    assign head = accept ? bias[j] : '0;

    if (j == 0) begin : g_one
      // Single-stage bias line for column 0
      always_ff @(posedge clk) begin
        if (reset) b_q <= '0;
        else       b_q <= head;
      end
    end else begin : g_many
      // Multi-stage bias line, shifts every cycle
      always_ff @(posedge clk) begin
        if (reset) b_q <= '0;
        else       b_q <= {b_q[(DEPTH-1)*BW-1:0], head};
      end
    end

    assign norths[j] = b_q[DEPTH*BW-1 -: BW];
  end
`else
  // Bias disabled: norths held at zero, bias input unused
  for (genvar j = 0; j < COL_NUM; j++) begin : g_col
    logic unused_bias;
    assign unused_bias = ^bias[j];
    assign norths[j]   = '0;
  end
`endif

endmodule

// File: tb/tb_systolic_ws_feeder.sv
// Bench for systolic_ws_feeder (4x4, 8-bit): scoreboard of per-lane queues
// plus scenario tasks with their own cycle-exact checks.
module tb_systolic_ws_feeder;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 8;
  localparam int BW = DW * 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [DW-1:0] in_data    [0:R-1];
  logic [BW-1:0] bias       [0:C-1];
  logic [DW-1:0] wests      [0:R-1];
  logic [R-1:0]  lane_valid;
  logic [BW-1:0] norths     [0:C-1];
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  systolic_ws_feeder #(
    .DATA_WIDTH (DW),
    .ROW_NUM    (R),
    .COL_NUM    (C)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_data    (in_data),
    .bias       (bias),
    .wests      (wests),
    .lane_valid (lane_valid),
    .norths     (norths),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] q_w [R][$];
  logic          q_v [R][$];
  logic [BW-1:0] q_n [C][$];
  longint        cyc        = 0;
  longint        drain_end  = -1;
  bit            streaming  = 0;
  bit            exp_ready  = 0;
  bit            exp_done   = 0;
  bit            exp_busy   = 0;

  always begin
    bit            acc;
    logic [DW-1:0] ew;
    logic          ev;
    logic [BW-1:0] en;
    @(posedge clk);
    cyc++;
    if (reset) begin
      for (int i = 0; i < R; i++) begin
        q_w[i].delete();
        q_v[i].delete();
        for (int k = 0; k <= i; k++) begin
          q_w[i].push_back('0);
          q_v[i].push_back(1'b0);
        end
      end
      for (int j = 0; j < C; j++) begin
        q_n[j].delete();
        for (int k = 0; k <= j; k++) q_n[j].push_back('0);
      end
      drain_end = -1;
      streaming = 0;
      exp_ready = 0;
    end else begin
      acc = in_valid && exp_ready;
      for (int i = 0; i < R; i++) begin
        q_w[i].push_back(acc ? in_data[i] : '0);
        q_v[i].push_back(acc);
      end
      for (int j = 0; j < C; j++) begin
`ifdef SYSTOLIC_WS_FEEDER_BIAS_EN
        q_n[j].push_back(acc ? bias[j] : '0);
`else
        q_n[j].push_back('0);
`endif
      end
      if (acc) begin
        if (in_last) begin
          drain_end = cyc - 1 + R + C;
          streaming = 0;
        end else begin
          streaming = 1;
        end
      end
      if (drain_end >= 0 && cyc > drain_end) drain_end = -1;
      exp_ready = (drain_end < 0);
    end
    exp_done = (drain_end >= 0) && (cyc == drain_end);
    exp_busy = streaming || (drain_end >= 0);
    #1;
    for (int i = 0; i < R; i++) begin
      ew = (q_w[i].size() > 0) ? q_w[i].pop_front() : 'x;
      ev = (q_v[i].size() > 0) ? q_v[i].pop_front() : 1'bx;
      checks++;
      if (wests[i] !== ew) begin
        errors++;
        $display("FAIL sb_west%0d cyc %0d: got %0h expected %0h", i, cyc, wests[i], ew);
      end
      checks++;
      if (lane_valid[i] !== ev) begin
        errors++;
        $display("FAIL sb_lane_valid%0d cyc %0d: got %0b expected %0b", i, cyc, lane_valid[i], ev);
      end
    end
    for (int j = 0; j < C; j++) begin
      en = (q_n[j].size() > 0) ? q_n[j].pop_front() : 'x;
      checks++;
      if (norths[j] !== en) begin
        errors++;
        $display("FAIL sb_north%0d cyc %0d: got %0h expected %0h", j, cyc, norths[j], en);
      end
    end
    checks++;
    if (in_ready !== exp_ready) begin
      errors++;
      $display("FAIL sb_in_ready cyc %0d: got %0b expected %0b", cyc, in_ready, exp_ready);
    end
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL sb_busy cyc %0d: got %0b expected %0b", cyc, busy, exp_busy);
    end
    checks++;
    if (done !== exp_done) begin
      errors++;
      $display("FAIL sb_done cyc %0d: got %0b expected %0b", cyc, done, exp_done);
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < R; i++) in_data[i] = '0;
    for (int j = 0; j < C; j++) bias[j] = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready === 1'b1 && busy === 1'b0) && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (!(in_ready === 1'b1 && busy === 1'b0)) begin
      errors++;
      $display("FAIL wait_idle_timeout: got ready=%0b busy=%0b expected ready=1 busy=0", in_ready, busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    repeat (3) step();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || lane_valid !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%0b busy=%0b done=%0b lv=%0h expected all 0",
               in_ready, busy, done, lane_valid);
    end
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %0b expected 1", in_ready);
    end
  endtask

  task automatic test_single();
    logic [BW-1:0] bv [0:C-1];
    logic [BW-1:0] en;
    wait_idle();
    bv = '{32'd10, 32'd20, 32'd30, 32'd40};
    in_data  = '{8'd1, 8'd2, 8'd3, 8'd4};
    bias     = bv;
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) drive_idle();
      checks++;
      if (in_ready !== (k >= 9)) begin
        errors++;
        $display("FAIL single_ready k%0d: got %0b expected %0b", k, in_ready, (k >= 9));
      end
      checks++;
      if (done !== (k == 8)) begin
        errors++;
        $display("FAIL single_done k%0d: got %0b expected %0b", k, done, (k == 8));
      end
      for (int r = 0; r < R; r++) begin
        checks++;
        if (wests[r] !== ((k == r + 1) ? 8'(r + 1) : 8'd0)) begin
          errors++;
          $display("FAIL single_west%0d k%0d: got %0h expected %0h", r, k, wests[r],
                   ((k == r + 1) ? 8'(r + 1) : 8'd0));
        end
      end
      for (int j = 0; j < C; j++) begin
`ifdef SYSTOLIC_WS_FEEDER_BIAS_EN
        en = (k == j + 1) ? bv[j] : '0;
`else
        en = '0;
`endif
        checks++;
        if (norths[j] !== en) begin
          errors++;
          $display("FAIL single_north%0d k%0d: got %0h expected %0h", j, k, norths[j], en);
        end
      end
    end
  endtask

  task automatic test_bubble();
    logic [DW-1:0] exp_w2 [0:3];
    wait_idle();
    exp_w2 = '{8'h13, 8'h23, 8'h00, 8'h33};
    in_data  = '{8'h11, 8'h12, 8'h13, 8'h14};
    in_valid = 1'b1;
    in_last  = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k == 1) begin
        in_data = '{8'h21, 8'h22, 8'h23, 8'h24};
      end else if (k == 2) begin
        in_valid = 1'b0;
        in_last  = 1'b1;
        in_data  = '{8'hEE, 8'hEE, 8'hEE, 8'hEE};
      end else if (k == 3) begin
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = '{8'h31, 8'h32, 8'h33, 8'h34};
      end else if (k == 4) begin
        drive_idle();
      end
      if (k >= 3 && k <= 6) begin
        checks++;
        if (wests[2] !== exp_w2[k-3]) begin
          errors++;
          $display("FAIL bubble_west2 k%0d: got %0h expected %0h", k, wests[2], exp_w2[k-3]);
        end
      end
      checks++;
      if (done !== (k == 11)) begin
        errors++;
        $display("FAIL bubble_done k%0d: got %0b expected %0b", k, done, (k == 11));
      end
    end
  endtask

  task automatic test_drain_ignore();
    wait_idle();
    in_data  = '{8'h09, 8'h09, 8'h09, 8'h09};
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k <= 8) begin
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      end else begin
        drive_idle();
      end
      for (int r = 0; r < R; r++) begin
        checks++;
        if (wests[r] === 8'hFF) begin
          errors++;
          $display("FAIL drain_west%0d k%0d: got %0h expected not ff", r, k, wests[r]);
        end
      end
      if (k >= 5) begin
        checks++;
        if (lane_valid !== '0) begin
          errors++;
          $display("FAIL drain_lane_valid k%0d: got %0h expected 0", k, lane_valid);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    wait_idle();
    in_valid = 1'b1;
    in_last  = 1'b0;
    in_data  = '{8'h41, 8'h42, 8'h43, 8'h44};
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k == 3) begin
        drive_idle();
        reset = 1'b1;
      end else if (k == 4) begin
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || lane_valid !== '0) begin
          errors++;
          $display("FAIL midreset_ctrl: got ready=%0b busy=%0b done=%0b lv=%0h expected all 0",
                   in_ready, busy, done, lane_valid);
        end
        for (int r = 0; r < R; r++) begin
          checks++;
          if (wests[r] !== '0) begin
            errors++;
            $display("FAIL midreset_west%0d: got %0h expected 0", r, wests[r]);
          end
        end
      end
      if (k == 5) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL midreset_ready: got %0b expected 1", in_ready);
        end
      end
      if (k >= 4) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL midreset_done k%0d: got %0b expected 0", k, done);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    bit seen;
    wait_idle();
    for (int v = 0; v < 12; v++) begin
      if (v > 0) step();
      in_valid = 1'b1;
      in_last  = (v == 11);
      for (int i = 0; i < R; i++) in_data[i] = DW'($urandom_range(0, 254));
      for (int j = 0; j < C; j++) bias[j] = BW'($urandom);
    end
    k = 11;
    seen = 0;
    while (!seen && k < 60) begin
      step();
      k++;
      if (k == 12) drive_idle();
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || k != 11 + R + C) begin
      errors++;
      $display("FAIL b2b_done_cycle: got %0d (seen=%0b) expected %0d", k, seen, 11 + R + C);
    end
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_after_done: got %0b expected 1", in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bubble();
    test_drain_ignore();
    test_reset_mid();
    test_back_to_back();
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
